// File: rtl/capi_xfer_split.sv
// capi_xfer_split: splits one beat-transfer request into chunk commands
// that never cross a 2^cwidth-beat aligned boundary.
// Optional statistics counters: define CAPI_XFER_SPLIT_STATS_EN.
module capi_xfer_split #(
    parameter int dwidth = 1,
    parameter int awidth = 16,
    parameter int lwidth = 8,
    parameter int cwidth = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_v,
    output logic              i_r,
    input  logic [dwidth-1:0] i_d,
    input  logic [awidth-1:0] i_ea,
    input  logic [lwidth-1:0] i_len,
    output logic              o_v,
    input  logic              o_r,
    output logic [dwidth-1:0] o_d,
    output logic [awidth-1:0] o_ea,
    output logic [cwidth-1:0] o_c,
    output logic              o_f,
    output logic              o_l
`ifdef CAPI_XFER_SPLIT_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_req,
    output logic [15:0]       stat_chk
`endif
);

    localparam int RW = lwidth + 1;
    localparam logic [RW-1:0] CHUNK = RW'(1) << cwidth;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              busy;
    logic [awidth-1:0] cur_ea;
    logic [RW-1:0]     rem;
    logic [dwidth-1:0] tag;
    logic              first;

    logic [RW-1:0]     room;
    logic [RW-1:0]     n;
    logic              last;
    logic              in_acc;
    logic              chk_acc;

    assign busy = (state == SPLIT);

    // Size of the chunk at cur_ea: limited by the remaining beats and
    // by the distance to the next aligned boundary.
    always_comb begin
        room = CHUNK - RW'(cur_ea[cwidth-1:0]);
        n    = (rem < room) ? rem : room;
        last = busy && (n == rem);
    end

    // Handshake qualifiers shared by the state and datapath updates.
    always_comb begin
        in_acc  = i_v & i_r;
        chk_acc = busy & o_r;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: a new request may be taken in the same cycle the
    // last chunk of the previous one is accepted.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_acc) begin
                    state_nx = SPLIT;
                end
            end
            SPLIT: begin
                if (chk_acc && last && !in_acc) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: chunk command presented straight from the registers.
    always_comb begin
        o_v  = busy;
        o_ea = cur_ea;
        o_d  = tag;
        o_f  = first;
        o_c  = n[cwidth-1:0];
        o_l  = last;
        i_r  = ~busy | (o_r & last);
    end

    // Request datapath: load on accept, advance on each non-last chunk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_ea <= '0;
            rem    <= '0;
            tag    <= '0;
            first  <= 1'b0;
        end else if (in_acc) begin
            cur_ea <= i_ea;
            rem    <= {(i_len == '0), i_len};
            tag    <= i_d;
            first  <= 1'b1;
        end else if (chk_acc) begin
            first <= 1'b0;
            if (!last) begin
                cur_ea <= cur_ea + awidth'(n);
                rem    <= rem - n;
            end
        end
    end

`ifdef CAPI_XFER_SPLIT_STATS_EN
    // Saturating request/chunk counters; a clear overrides an increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_req <= '0;
            stat_chk <= '0;
        end else if (stat_clr) begin
            stat_req <= '0;
            stat_chk <= '0;
        end else begin
            if (in_acc && stat_req != 16'hFFFF) begin
                stat_req <= stat_req + 16'd1;
            end
            if (chk_acc && stat_chk != 16'hFFFF) begin
                stat_chk <= stat_chk + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_capi_xfer_split.sv
// tb_capi_xfer_split: directed table plus hand sequences for the
// chunk splitter with cwidth=2, awidth=8, lwidth=4.
module tb_capi_xfer_split;

    localparam int DW = 4;
    localparam int AW = 8;
    localparam int LW = 4;
    localparam int CW = 2;

    logic          clk;
    logic          reset;
    logic          i_v;
    logic          i_r;
    logic [DW-1:0] i_d;
    logic [AW-1:0] i_ea;
    logic [LW-1:0] i_len;
    logic          o_v;
    logic          o_r;
    logic [DW-1:0] o_d;
    logic [AW-1:0] o_ea;
    logic [CW-1:0] o_c;
    logic          o_f;
    logic          o_l;
`ifdef CAPI_XFER_SPLIT_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_req;
    logic [15:0]   stat_chk;
`endif

    int errs;
    int checks;

    capi_xfer_split #(
        .dwidth(DW),
        .awidth(AW),
        .lwidth(LW),
        .cwidth(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .i_v  (i_v),
        .i_r  (i_r),
        .i_d  (i_d),
        .i_ea (i_ea),
        .i_len(i_len),
        .o_v  (o_v),
        .o_r  (o_r),
        .o_d  (o_d),
        .o_ea (o_ea),
        .o_c  (o_c),
        .o_f  (o_f),
        .o_l  (o_l)
`ifdef CAPI_XFER_SPLIT_STATS_EN
        ,
        .stat_clr(stat_clr),
        .stat_req(stat_req),
        .stat_chk(stat_chk)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic [AW-1:0] iea;
        logic [LW-1:0] ilen;
        logic          orr;
        logic          full;
        logic          ov;
        logic          ir;
        logic [AW-1:0] oea;
        logic [CW-1:0] oc;
        logic          of;
        logic          ol;
        logic [DW-1:0] od;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic ov, input logic ir,
                           input logic [AW-1:0] ea, input logic [CW-1:0] c,
                           input logic f, input logic l,
                           input logic [DW-1:0] d);
        chk({nm, " o_v"}, 32'(o_v), 32'(ov));
        chk({nm, " i_r"}, 32'(i_r), 32'(ir));
        chk({nm, " o_ea"}, 32'(o_ea), 32'(ea));
        chk({nm, " o_c"}, 32'(o_c), 32'(c));
        chk({nm, " o_f"}, 32'(o_f), 32'(f));
        chk({nm, " o_l"}, 32'(o_l), 32'(l));
        chk({nm, " o_d"}, 32'(o_d), 32'(d));
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        reset  = 1'b0;
        i_v    = 1'b0;
        i_d    = '0;
        i_ea   = '0;
        i_len  = '0;
        o_r    = 1'b1;
`ifdef CAPI_XFER_SPLIT_STATS_EN
        stat_clr = 1'b0;
`endif

        // iv id iea ilen orr full | ov ir oea oc of ol od
        vecs[0]  = '{0, 0, 8'h00, 0, 1, 1, 0, 1, 8'h00, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 8'h00, 4, 1, 1, 0, 1, 8'h00, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 8'h00, 0, 1, 1, 1, 1, 8'h00, 0, 1, 1, 1};
        vecs[3]  = '{1, 2, 8'h03, 6, 1, 0, 0, 1, 8'h00, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h03, 1, 1, 0, 2};
        vecs[5]  = '{0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h04, 0, 0, 0, 2};
        vecs[6]  = '{0, 0, 8'h00, 0, 1, 1, 1, 1, 8'h08, 1, 0, 1, 2};
        vecs[7]  = '{1, 3, 8'hFE, 0, 1, 0, 0, 1, 8'h00, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 8'h00, 0, 1, 1, 1, 0, 8'hFE, 2, 1, 0, 3};
        vecs[9]  = '{0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 3};
        vecs[10] = '{0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h04, 0, 0, 0, 3};
        vecs[11] = '{0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h08, 0, 0, 0, 3};
        vecs[12] = '{0, 0, 8'h00, 0, 1, 1, 1, 1, 8'h0C, 2, 0, 1, 3};
        vecs[13] = '{0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h00, 0, 0, 0, 0};

        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            i_v   = vecs[k].iv;
            i_d   = vecs[k].id;
            i_ea  = vecs[k].iea;
            i_len = vecs[k].ilen;
            o_r   = vecs[k].orr;
            #1;
            if (vecs[k].full) begin
                chk_all($sformatf("vec%0d", k), vecs[k].ov, vecs[k].ir,
                        vecs[k].oea, vecs[k].oc, vecs[k].of, vecs[k].ol,
                        vecs[k].od);
            end else begin
                chk($sformatf("vec%0d o_v", k), 32'(o_v), 32'(vecs[k].ov));
                chk($sformatf("vec%0d i_r", k), 32'(i_r), 32'(vecs[k].ir));
            end
        end

`ifdef CAPI_XFER_SPLIT_STATS_EN
        chk("stat_req", 32'(stat_req), 32'd3);
        chk("stat_chk", 32'(stat_chk), 32'd9);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        chk("stat_req clr", 32'(stat_req), 32'd0);
        chk("stat_chk clr", 32'(stat_chk), 32'd0);
`endif

        // Backpressure on the last chunk, then back-to-back request.
        @(negedge clk);
        i_v = 1'b1; i_d = 4'h5; i_ea = 8'h20; i_len = 4'd8; o_r = 1'b1;
        @(negedge clk);
        i_v = 1'b0;
        #1;
        chk_all("bp c1", 1, 0, 8'h20, 0, 1, 0, 4'h5);
        @(negedge clk);
        o_r = 1'b0;
        i_v = 1'b1; i_d = 4'h6; i_ea = 8'h10; i_len = 4'd1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_all($sformatf("bp hold%0d", k), 1, 0, 8'h24, 0, 0, 1, 4'h5);
            @(negedge clk);
        end
        o_r = 1'b1;
        #1;
        chk_all("bp release", 1, 1, 8'h24, 0, 0, 1, 4'h5);
        @(negedge clk);
        i_v = 1'b0;
        #1;
        chk_all("b2b chunk", 1, 1, 8'h10, 1, 1, 1, 4'h6);
        @(negedge clk);
        #1;
        chk("b2b idle o_v", 32'(o_v), 32'd0);

        // Reset asserted during the second chunk.
        @(negedge clk);
        i_v = 1'b1; i_d = 4'h7; i_ea = 8'h00; i_len = 4'd12;
        @(negedge clk);
        i_v = 1'b0;
        #1;
        chk_all("rst c1", 1, 0, 8'h00, 0, 1, 0, 4'h7);
        @(negedge clk);
        #1;
        chk_all("rst c2", 1, 0, 8'h04, 0, 0, 0, 4'h7);
        #1;
        reset = 1'b0;
        #1;
        chk("rst async o_v", 32'(o_v), 32'd0);
        chk("rst async i_r", 32'(i_r), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("post rst%0d o_v", k), 32'(o_v), 32'd0);
            chk($sformatf("post rst%0d i_r", k), 32'(i_r), 32'd1);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
